// File: rtl/te_retire_fifo.sv
// Retirement bundle capture FIFO ahead of the trace-encoder serializer.
// Optional drop counter port drop_cnt_o: define TE_RETIRE_FIFO_DROP_CNT_EN.
module te_retire_fifo #(
    parameter int NRET      = 2,
    parameter int XLEN      = 64,
    parameter int ITYPE_LEN = 3,
    parameter int CAUSE_LEN = 5,
    parameter int PRIV_LEN  = 2,
    parameter int DEPTH     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NRET-1:0]           iretire_i,
    input  logic [NRET-1:0]           ilastsize_i,
    input  logic [NRET*ITYPE_LEN-1:0] itype_i,
    input  logic [NRET*XLEN-1:0]      iaddr_i,
    input  logic [CAUSE_LEN-1:0]      cause_i,
    input  logic [XLEN-1:0]           tval_i,
    input  logic [PRIV_LEN-1:0]       priv_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [NRET-1:0]           iretire_o,
    output logic [NRET-1:0]           ilastsize_o,
    output logic [NRET*ITYPE_LEN-1:0] itype_o,
    output logic [NRET*XLEN-1:0]      iaddr_o,
    output logic [CAUSE_LEN-1:0]      cause_o,
    output logic [XLEN-1:0]           tval_o,
    output logic [PRIV_LEN-1:0]       priv_o,
    output logic [$clog2(DEPTH):0]    count_o,
`ifdef TE_RETIRE_FIFO_DROP_CNT_EN
    output logic [15:0]               drop_cnt_o,
`endif
    output logic                      overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = 2*NRET + NRET*ITYPE_LEN + NRET*XLEN
                      + CAUSE_LEN + XLEN + PRIV_LEN;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] din;
    logic [W-1:0] head;
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_ptr_n;
    logic [AW:0]  rd_ptr_n;
    logic         empty;
    logic         full;
    logic         push;
    logic         pop;
    logic         wr_en;
    logic         drop;

    assign din = {priv_i, tval_i, cause_i, iaddr_i,
                  itype_i, ilastsize_i, iretire_i};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign push  = (|iretire_i) | (|itype_i);
    assign pop   = valid_o & ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    assign wr_ptr_n = wr_ptr + (AW+1)'(wr_en);
    assign rd_ptr_n = rd_ptr + (AW+1)'(pop);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            count_o    <= wr_ptr_n - rd_ptr_n;
            overflow_o <= overflow_o | drop;
        end
    end

`ifdef TE_RETIRE_FIFO_DROP_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else if (drop && drop_cnt_o != 16'hFFFF) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif

    assign valid_o = ~empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign {priv_o, tval_o, cause_o, iaddr_o,
            itype_o, ilastsize_o, iretire_o} = head;

endmodule

// File: tb/tb_te_retire_fifo.sv
// Scoreboard bench for te_retire_fifo: reference queue of accepted bundles,
// independent monitor comparing the head and status every cycle.
module tb_te_retire_fifo;

    localparam int NRET  = 2;
    localparam int XLEN  = 64;
    localparam int IT    = 3;
    localparam int CL    = 5;
    localparam int PL    = 2;
    localparam int DEPTH = 8;
    localparam int W     = 2*NRET + NRET*IT + NRET*XLEN + CL + XLEN + PL;

    typedef logic [W-1:0] bundle_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NRET-1:0]      iretire_i = '0;
    logic [NRET-1:0]      ilastsize_i = '0;
    logic [NRET*IT-1:0]   itype_i = '0;
    logic [NRET*XLEN-1:0] iaddr_i = '0;
    logic [CL-1:0]        cause_i = '0;
    logic [XLEN-1:0]      tval_i = '0;
    logic [PL-1:0]        priv_i = '0;
    logic                 ready_i = 1'b0;
    logic                 valid_o;
    logic [NRET-1:0]      iretire_o;
    logic [NRET-1:0]      ilastsize_o;
    logic [NRET*IT-1:0]   itype_o;
    logic [NRET*XLEN-1:0] iaddr_o;
    logic [CL-1:0]        cause_o;
    logic [XLEN-1:0]      tval_o;
    logic [PL-1:0]        priv_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                 overflow_o;
`ifdef TE_RETIRE_FIFO_DROP_CNT_EN
    logic [15:0]          drop_cnt_o;
`endif

    te_retire_fifo #(
        .NRET(NRET), .XLEN(XLEN), .ITYPE_LEN(IT),
        .CAUSE_LEN(CL), .PRIV_LEN(PL), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i),
        .itype_i(itype_i), .iaddr_i(iaddr_i),
        .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
        .itype_o(itype_o), .iaddr_o(iaddr_o),
        .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
        .count_o(count_o),
`ifdef TE_RETIRE_FIFO_DROP_CNT_EN
        .drop_cnt_o(drop_cnt_o),
`endif
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    bundle_t in_b;
    bundle_t out_b;
    assign in_b  = {priv_i, tval_i, cause_i, iaddr_i, itype_i, ilastsize_i, iretire_i};
    assign out_b = {priv_o, tval_o, cause_o, iaddr_o, itype_o, ilastsize_o, iretire_o};

    int      n_cmp = 0;
    int      n_bad = 0;
    bundle_t sb[$];
    bit      ovf_exp = 1'b0;
    int      drop_exp = 0;

    function automatic void chk(bit ok, string name, bundle_t act, bundle_t exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: the FIFO is an ordered list of accepted bundles, capacity DEPTH.
    // The monitor removes the head on a handshake before this edge runs.
    always @(posedge clk_i) begin
        if (rst_i) begin
            sb.delete();
            ovf_exp  = 1'b0;
            drop_exp = 0;
        end else if ((|iretire_i) || (|itype_i)) begin
            if (sb.size() < DEPTH) begin
                sb.push_back(in_b);
            end else begin
                ovf_exp = 1'b1;
                if (drop_exp < 65535) drop_exp++;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            chk(!valid_o && count_o == 0 && !overflow_o && out_b == '0,
                "reset_state", out_b, '0);
        end else begin
            chk(count_o == ($clog2(DEPTH)+1)'(sb.size()), "count",
                W'(count_o), W'(sb.size()));
            chk(valid_o == (sb.size() != 0), "valid", W'(valid_o), W'(sb.size() != 0));
            chk(overflow_o == ovf_exp, "overflow", W'(overflow_o), W'(ovf_exp));
`ifdef TE_RETIRE_FIFO_DROP_CNT_EN
            chk(drop_cnt_o == 16'(drop_exp), "drop_cnt", W'(drop_cnt_o), W'(drop_exp));
`endif
            if (sb.size() != 0) begin
                chk(out_b == sb[0], "head", out_b, sb[0]);
                if (valid_o && ready_i) void'(sb.pop_front());
            end else begin
                chk(out_b == '0, "empty_data", out_b, '0);
            end
        end
    end

    task automatic drive_full(input logic [NRET-1:0] ir, input logic [NRET-1:0] ls,
                              input logic [NRET*IT-1:0] it, input logic [NRET*XLEN-1:0] ia,
                              input logic [CL-1:0] c, input logic [XLEN-1:0] tv,
                              input logic [PL-1:0] pr, input logic rdy);
        iretire_i   = ir;
        ilastsize_i = ls;
        itype_i     = it;
        iaddr_i     = ia;
        cause_i     = c;
        tval_i      = tv;
        priv_i      = pr;
        ready_i     = rdy;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [NRET-1:0] ir, input logic [NRET*IT-1:0] it,
                         input logic [NRET*XLEN-1:0] ia, input logic rdy);
        drive_full(ir, NRET'($urandom), it, ia, CL'($urandom),
                   {$urandom, $urandom}, PL'($urandom), rdy);
    endtask

    function automatic logic [NRET*XLEN-1:0] raddr();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rand_cycle(input int idle_pct, input logic rdy);
        logic [NRET-1:0]    ir;
        logic [NRET*IT-1:0] it;
        ir = NRET'($urandom);
        it = ($urandom_range(0, 3) == 0) ? (NRET*IT)'($urandom) : '0;
        if ($urandom_range(0, 99) < idle_pct) begin
            ir = '0;
            it = '0;
        end
        drive(ir, it, raddr(), rdy);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) rand_cycle(0, 1'($urandom));
        rst_i = 1'b0;
    endtask

    initial begin
        do_reset();

        // Order and latency
        drive(2'b11, '0, {64'h1004, 64'h1000}, 1'b0);
        drive(2'b01, '0, {{$urandom, $urandom}, 64'h1008}, 1'b0);
        drive('0, '0, raddr(), 1'b0);
        drive('0, '0, raddr(), 1'b0);
        repeat (3) drive('0, '0, raddr(), 1'b1);

        // Push filter and exception-only bundle
        repeat (5) drive('0, '0, raddr(), 1'b0);
        drive_full('0, '0, 6'b000_001, raddr(), 5'd2, 64'hDEAD, 2'd3, 1'b0);
        drive('0, '0, raddr(), 1'b0);
        repeat (2) drive('0, '0, raddr(), 1'b1);

        // Full and overflow
        for (int i = 0; i < 9; i++)
            drive(2'b01, '0, {{$urandom, $urandom}, 64'(i * 4)}, 1'b0);
        drive('0, '0, raddr(), 1'b0);
        repeat (10) drive('0, '0, raddr(), 1'b1);

        // Push and pop while full
        do_reset();
        for (int i = 0; i < 8; i++)
            drive(2'b11, '0, raddr(), 1'b0);
        drive(2'b10, '0, raddr(), 1'b1);
        drive('0, '0, raddr(), 1'b0);
        repeat (10) drive('0, '0, raddr(), 1'b1);

        // Asynchronous reset mid-cycle, then pointer wrap
        for (int i = 0; i < 5; i++)
            drive(2'b01, '0, raddr(), 1'b0);
        iretire_i = '0;
        itype_i   = '0;
        #2 rst_i = 1'b1;
        #1;
        chk(!valid_o && count_o == 0 && !overflow_o && out_b == '0,
            "async_reset", out_b, '0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 20; i++)
            drive(2'b01, '0, raddr(), 1'b1);
        repeat (2) drive('0, '0, raddr(), 1'b1);

        // Randomized traffic with bursts and back-pressure
        for (int i = 0; i < 600; i++)
            rand_cycle(30, ($urandom_range(0, 99) < 45));
        repeat (12) drive('0, '0, raddr(), 1'b1);

        chk(sb.size() == 0, "drained", W'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
